// File: rtl/xillybus_mem_bridge_if.sv
// Host-side stream bundle of the seekable memory endpoint: the read stream,
// the write stream and the shared seek address, as seen by xillybus_core.
interface xillybus_mem_bridge_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              user_r_mem_rden;
  logic [DATA_W-1:0] user_r_mem_data;
  logic              user_r_mem_empty;
  logic              user_r_mem_eof;
  logic              user_r_mem_open;
  logic              user_w_mem_wren;
  logic [DATA_W-1:0] user_w_mem_data;
  logic              user_w_mem_full;
  logic              user_w_mem_open;
  logic [ADDR_W-1:0] user_mem_addr;
  logic              user_mem_addr_update;

  // The bridge is the slave: it answers the core's strobes.
  modport slave (
    input  user_r_mem_rden, user_r_mem_open,
    input  user_w_mem_wren, user_w_mem_data, user_w_mem_open,
    input  user_mem_addr, user_mem_addr_update,
    output user_r_mem_data, user_r_mem_empty, user_r_mem_eof,
    output user_w_mem_full
  );

  // The core (or a bench standing in for it) drives the strobes.
  modport master (
    output user_r_mem_rden, user_r_mem_open,
    output user_w_mem_wren, user_w_mem_data, user_w_mem_open,
    output user_mem_addr, user_mem_addr_update,
    input  user_r_mem_data, user_r_mem_empty, user_r_mem_eof,
    input  user_w_mem_full
  );
endinterface

// File: rtl/xillybus_mem_bridge.sv
// Seekable memory endpoint for a Xillybus address-capable stream pair.
// Host side: one auto-incrementing pointer shared by both streams, with a
// one-word prefetch register so back-to-back reads run at one word per clock.
// Fabric side: an independent registered random-access port and a dirty flag.
module xillybus_mem_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  xillybus_mem_bridge_if.slave  host,
  input  logic [ADDR_W-1:0]     app_addr,
  input  logic                  app_wren,
  input  logic [DATA_W-1:0]     app_wdata,
  output logic [DATA_W-1:0]     app_rdata,
  output logic                  dirty,
  input  logic                  dirty_clr
);

  localparam int              DEPTH       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic            STOP_AT_END = (WRAP == 1'b0);

  // Storage: host port and app port, both with registered reads only.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Pointer and prefetch state.
  logic [ADDR_W-1:0] r_ptr;
  logic              r_at_end;
  logic              r_pf_valid;
  logic [DATA_W-1:0] r_pf_data;
  logic              r_wren_last;
  logic              r_dirty;
  logic [DATA_W-1:0] r_app_rdata;

  // Per-cycle decisions.
  logic              w_update;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ptr_last;
  logic              w_end_hit;
  logic              w_fill;
  logic              w_pf_load;
  logic              w_app_hit;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic [ADDR_W-1:0] w_host_addr;
  logic              w_unused;

  // The write-file open flag has no effect on the pointer or the data path.
  assign w_unused = host.user_w_mem_open;

  assign w_update   = host.user_mem_addr_update;
  assign w_full     = r_at_end & STOP_AT_END;

  // Any write activity (this cycle or last) hides the prefetch word, so a
  // read can never overtake a write that is still landing in the array.
  assign w_empty    = ~r_pf_valid | ~host.user_r_mem_open | r_at_end
                    | host.user_w_mem_wren | r_wren_last;

  // Priority: seek beats write, write beats read.
  assign w_wr_acc   = host.user_w_mem_wren & ~w_full & ~w_update;
  assign w_rd_acc   = host.user_r_mem_rden & ~w_empty & ~w_update & ~w_wr_acc;

  assign w_ptr_last = (r_ptr == LAST_ADDR);
  assign w_ptr_inc  = r_ptr + ADDR_W'(1);
  // A transfer at the last word either wraps (natural overflow of w_ptr_inc)
  // or parks the pointer and raises at_end.
  assign w_end_hit  = w_ptr_last & STOP_AT_END;

  // Refill an invalid prefetch only when the pointer is stable this cycle.
  assign w_fill     = ~r_pf_valid & host.user_r_mem_open & ~r_at_end
                    & ~host.user_w_mem_wren & ~w_update;

  // A pop fetches the next word right away to keep one word per clock.
  assign w_pf_load  = w_fill | (w_rd_acc & ~w_end_hit);
  assign w_host_addr = w_rd_acc ? w_ptr_inc : r_ptr;

  // App writes that land on the word held (or being fetched) by the
  // prefetch register invalidate it; the refill then sees the new value.
  assign w_app_hit  = app_wren & ((app_addr == r_ptr)
                    | (w_rd_acc & (app_addr == w_ptr_inc)));

  // Pointer, end-of-memory flag and prefetch-valid bookkeeping.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_ptr       <= '0;
      r_at_end    <= 1'b0;
      r_pf_valid  <= 1'b0;
      r_wren_last <= 1'b0;
    end else begin
      r_wren_last <= host.user_w_mem_wren;
      if (w_update) begin
        r_ptr      <= host.user_mem_addr;
        r_at_end   <= 1'b0;
        r_pf_valid <= 1'b0;
      end else if (w_wr_acc || w_rd_acc) begin
        if (w_end_hit) begin
          r_at_end <= 1'b1;
        end else begin
          r_ptr <= w_ptr_inc;
        end
        r_pf_valid <= w_rd_acc & ~w_end_hit;
      end else if (w_fill) begin
        r_pf_valid <= 1'b1;
      end
      if (!host.user_r_mem_open || w_app_hit) begin
        r_pf_valid <= 1'b0;
      end
    end
  end

  // Array writes: the host write is issued last so it wins an address clash.
  always_ff @(posedge bus_clk) begin
    if (app_wren) begin
      r_mem[app_addr] <= app_wdata;
    end
    if (w_wr_acc) begin
      r_mem[r_ptr] <= host.user_w_mem_data;
    end
  end

  // Host-port registered read feeding the prefetch word.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_pf_data <= '0;
    end else if (w_pf_load) begin
      r_pf_data <= r_mem[w_host_addr];
    end
  end

  // App-port registered read; returns the pre-write contents on a clash.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_app_rdata <= '0;
    end else begin
      r_app_rdata <= r_mem[app_addr];
    end
  end

  // Dirty flag: an accepted host write outranks a simultaneous clear.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_dirty <= 1'b0;
    end else if (w_wr_acc) begin
      r_dirty <= 1'b1;
    end else if (dirty_clr) begin
      r_dirty <= 1'b0;
    end
  end

  assign host.user_r_mem_data  = r_pf_data;
  assign host.user_r_mem_empty = w_empty;
  assign host.user_r_mem_eof   = r_at_end & STOP_AT_END;
  assign host.user_w_mem_full  = w_full;
  assign app_rdata             = r_app_rdata;
  assign dirty                 = r_dirty;

endmodule

// File: tb/tb_xillybus_mem_bridge.sv
// Bench for xillybus_mem_bridge: a wrapping and a stop-at-end instance share
// one stimulus; table vectors, directed corner sequences and a randomized run
// against a word-level memory model.
module tb_xillybus_mem_bridge;

  logic       clk;
  logic       rst_n;
  logic       rden, r_open, wren, w_open, upd, awren, dclr;
  logic [7:0] wdata, awdata;
  logic [4:0] maddr, aaddr;
  logic [7:0] app_rdata1, app_rdata0;
  logic       dirty1, dirty0;

  int checks = 0;
  int errors = 0;

  xillybus_mem_bridge_if #(.DATA_W(8), .ADDR_W(5)) if1 ();
  xillybus_mem_bridge_if #(.DATA_W(8), .ADDR_W(5)) if0 ();

  assign if1.user_r_mem_rden      = rden;
  assign if1.user_r_mem_open      = r_open;
  assign if1.user_w_mem_wren      = wren;
  assign if1.user_w_mem_data      = wdata;
  assign if1.user_w_mem_open      = w_open;
  assign if1.user_mem_addr        = maddr;
  assign if1.user_mem_addr_update = upd;
  assign if0.user_r_mem_rden      = rden;
  assign if0.user_r_mem_open      = r_open;
  assign if0.user_w_mem_wren      = wren;
  assign if0.user_w_mem_data      = wdata;
  assign if0.user_w_mem_open      = w_open;
  assign if0.user_mem_addr        = maddr;
  assign if0.user_mem_addr_update = upd;

  xillybus_mem_bridge #(.DATA_W(8), .ADDR_W(5), .WRAP(1'b1)) u_dut (
    .bus_clk(clk), .bus_rst_n(rst_n), .host(if1),
    .app_addr(aaddr), .app_wren(awren), .app_wdata(awdata),
    .app_rdata(app_rdata1), .dirty(dirty1), .dirty_clr(dclr)
  );

  xillybus_mem_bridge #(.DATA_W(8), .ADDR_W(5), .WRAP(1'b0)) u_dut0 (
    .bus_clk(clk), .bus_rst_n(rst_n), .host(if0),
    .app_addr(aaddr), .app_wren(awren), .app_wdata(awdata),
    .app_rdata(app_rdata0), .dirty(dirty0), .dirty_clr(dclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0b exp=%0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rden = 1'b0; wren = 1'b0; upd = 1'b0; awren = 1'b0; dclr = 1'b0;
  endtask

  typedef struct {
    bit       upd;
    bit [4:0] maddr;
    bit       wren;
    bit [7:0] wdata;
    bit [4:0] aaddr;
    bit       awren;
    bit [7:0] awdata;
    bit       dclr;
    bit       chk_rd;
    bit [7:0] exp_rdata;
    bit       exp_dirty;
  } vec_t;

  vec_t vt [17];

  // random-phase model
  logic [7:0] m_mem [32];
  logic [4:0] m_ptr;
  logic       m_dirty;
  logic       m_wren_last;
  logic [7:0] m_app_exp;
  logic       have_app;
  logic       host_wr;
  logic [4:0] haddr;
  logic       rd_ok;
  int         pops;
  logic [7:0] burst [3];

  initial begin
    idle();
    r_open = 1'b0; w_open = 1'b0;
    maddr = '0; aaddr = '0; wdata = '0; awdata = '0;
    rst_n = 1'b0;

    //                upd ma  wr wdata  aa  aw awdata dc ck  exp    dirty
    vt[0]  = '{1'b1, 5'd3,  1'b0, 8'h00, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 5'd0,  1'b1, 8'hA1, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[2]  = '{1'b0, 5'd0,  1'b1, 8'hB2, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[3]  = '{1'b0, 5'd0,  1'b1, 8'hC3, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[4]  = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd3,  1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b1};
    vt[5]  = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd4,  1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b1};
    vt[6]  = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd5,  1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0};
    vt[7]  = '{1'b0, 5'd0,  1'b1, 8'hD4, 5'd0,  1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    vt[8]  = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd6,  1'b0, 8'h00, 1'b0, 1'b1, 8'hD4, 1'b1};
    vt[9]  = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd7,  1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[10] = '{1'b1, 5'd10, 1'b1, 8'h77, 5'd7,  1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1};
    vt[11] = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd7,  1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1};
    vt[12] = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd0,  1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[13] = '{1'b0, 5'd0,  1'b1, 8'h99, 5'd10, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[14] = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd10, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1};
    vt[15] = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd12, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[16] = '{1'b0, 5'd0,  1'b0, 8'h00, 5'd12, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1};

    // ---- reset values ----
    #3;
    chk1("rst_empty", if1.user_r_mem_empty, 1'b1);
    chk1("rst_eof",   if0.user_r_mem_eof,   1'b0);
    chk1("rst_full",  if0.user_w_mem_full,  1'b0);
    chk8("rst_data",  if1.user_r_mem_data,  8'h00);
    chk8("rst_app",   app_rdata1,           8'h00);
    chk1("rst_dirty", dirty1,               1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- table vectors: seek/write, app port, dirty, collisions ----
    for (int i = 0; i < 17; i++) begin
      upd = vt[i].upd; maddr = vt[i].maddr; wren = vt[i].wren; wdata = vt[i].wdata;
      aaddr = vt[i].aaddr; awren = vt[i].awren; awdata = vt[i].awdata; dclr = vt[i].dclr;
      tick();
      $display("vec %0d upd=%0b wr=%0b wd=%0h aa=%0d aw=%0b app_rdata=%0h dirty=%0b",
               i, vt[i].upd, vt[i].wren, vt[i].wdata, vt[i].aaddr, vt[i].awren,
               app_rdata1, dirty1);
      if (vt[i].chk_rd) chk8($sformatf("vec%0d_app_rdata", i), app_rdata1, vt[i].exp_rdata);
      chk1($sformatf("vec%0d_dirty", i), dirty1, vt[i].exp_dirty);
    end
    idle();

    // ---- seek then burst read ----
    r_open = 1'b1; upd = 1'b1; maddr = 5'd3;
    tick(); idle(); #1;
    chk1("seek_empty_c1", if1.user_r_mem_empty, 1'b1);
    tick(); #1;
    chk1("seek_empty_c2", if1.user_r_mem_empty, 1'b0);
    burst[0] = 8'hA1; burst[1] = 8'hB2; burst[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      rden = 1'b1; #1;
      $display("burst %0d data=%0h empty=%0b", i, if1.user_r_mem_data, if1.user_r_mem_empty);
      chk8("burst_data", if1.user_r_mem_data, burst[i]);
      chk1("burst_empty", if1.user_r_mem_empty, 1'b0);
      tick();
    end
    rden = 1'b0; #1;
    chk8("burst_next_data", if1.user_r_mem_data, 8'hD4);
    chk1("burst_dirty", dirty1, 1'b1);

    // ---- app write to the prefetched word ----
    aaddr = 5'd6; awren = 1'b1; awdata = 8'h55;
    tick(); awren = 1'b0; #1;
    chk1("coh_empty_pulse", if1.user_r_mem_empty, 1'b1);
    tick(); #1;
    chk1("coh_empty_back", if1.user_r_mem_empty, 1'b0);
    chk8("coh_data", if1.user_r_mem_data, 8'h55);

    // ---- wrap at the last word (both instances) ----
    upd = 1'b1; maddr = 5'd31;
    tick(); idle();
    wren = 1'b1; wdata = 8'h11;
    tick(); #1;
    chk1("w0_full_after_last", if0.user_w_mem_full, 1'b1);
    chk1("w0_eof_after_last",  if0.user_r_mem_eof,  1'b1);
    wdata = 8'h22;
    tick(); wren = 1'b0;
    upd = 1'b1; maddr = 5'd31;
    tick(); upd = 1'b0;
    tick(); #1;
    chk8("wrap_data31", if1.user_r_mem_data, 8'h11);
    chk1("w0_reseek_empty", if0.user_r_mem_empty, 1'b0);
    rden = 1'b1;
    tick(); rden = 1'b0; #1;
    chk8("wrap_data0", if1.user_r_mem_data, 8'h22);
    chk1("wrap_empty", if1.user_r_mem_empty, 1'b0);
    chk1("w0_eof_read_last", if0.user_r_mem_eof, 1'b1);
    chk1("w0_empty_at_end",  if0.user_r_mem_empty, 1'b1);
    aaddr = 5'd31; tick();
    chk8("wrap_mem31", app_rdata1, 8'h11);
    aaddr = 5'd0; tick();
    chk8("wrap_mem0", app_rdata1, 8'h22);

    // ---- stop-at-end: read 30,31 then end; write refused ----
    upd = 1'b1; maddr = 5'd30;
    tick(); upd = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      rden = 1'b1; #1;
      chk1("w0_read_avail", if0.user_r_mem_empty, 1'b0);
      tick();
    end
    rden = 1'b0; #1;
    chk1("w0_eof",   if0.user_r_mem_eof,   1'b1);
    chk1("w0_empty", if0.user_r_mem_empty, 1'b1);
    chk1("w0_full",  if0.user_w_mem_full,  1'b1);
    dclr = 1'b1;
    tick(); dclr = 1'b0;
    wren = 1'b1; wdata = 8'hEE;
    tick(); wren = 1'b0;
    aaddr = 5'd31;
    tick();
    chk1("w0_refused_dirty", dirty0, 1'b0);
    chk1("w1_accepted_dirty", dirty1, 1'b1);
    chk8("w0_refused_mem", app_rdata0, 8'h11);
    upd = 1'b1; maddr = 5'd0;
    tick(); upd = 1'b0; #1;
    chk1("w0_seek_eof",  if0.user_r_mem_eof,  1'b0);
    chk1("w0_seek_full", if0.user_w_mem_full, 1'b0);

    // ---- reset in the middle of a read burst ----
    upd = 1'b1; maddr = 5'd3;
    tick(); upd = 1'b0;
    tick();
    rden = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk8("mid_rst_data",  if1.user_r_mem_data,  8'h00);
    chk1("mid_rst_empty", if1.user_r_mem_empty, 1'b1);
    chk1("mid_rst_dirty", dirty1,               1'b0);
    chk8("mid_rst_app",   app_rdata1,           8'h00);
    chk1("mid_rst_eof",   if0.user_r_mem_eof,   1'b0);
    chk1("mid_rst_full",  if0.user_w_mem_full,  1'b0);
    rden = 1'b0; r_open = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); #1;
    chk1("post_rst_closed_empty", if1.user_r_mem_empty, 1'b1);
    r_open = 1'b1;
    tick(); #1;
    chk1("post_rst_open_empty", if1.user_r_mem_empty, 1'b0);
    chk8("post_rst_ptr0_data",  if1.user_r_mem_data,  8'hEE);

    // ---- randomized run against the memory model (wrapping instance) ----
    r_open = 1'b0; idle();
    for (int a = 0; a < 32; a++) begin
      aaddr = 5'(a); awren = 1'b1; awdata = 8'($urandom); dclr = (a == 0);
      m_mem[a] = awdata;
      tick();
    end
    idle();
    upd = 1'b1; maddr = 5'd0;
    tick(); upd = 1'b0;
    m_ptr = 5'd0; m_dirty = 1'b0; m_wren_last = 1'b0; have_app = 1'b0;
    m_app_exp = 8'h00; pops = 0; r_open = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      upd    = ($urandom_range(0, 15) == 0);
      maddr  = 5'($urandom);
      wren   = ($urandom_range(0, 4) == 0);
      wdata  = 8'($urandom);
      rden   = ($urandom_range(0, 1) == 1);
      awren  = ($urandom_range(0, 3) == 0);
      aaddr  = ($urandom_range(0, 1) == 1) ? m_ptr : 5'($urandom);
      awdata = 8'($urandom);
      dclr   = ($urandom_range(0, 7) == 0);
      if (r_open && $urandom_range(0, 63) == 0) r_open = 1'b0;
      else if (!r_open && $urandom_range(0, 3) == 0) r_open = 1'b1;
      #1;
      if (!if1.user_r_mem_empty) chk8("rnd_data", if1.user_r_mem_data, m_mem[m_ptr]);
      if (!r_open || wren || m_wren_last) chk1("rnd_empty", if1.user_r_mem_empty, 1'b1);
      chk1("rnd_dirty", dirty1, m_dirty);
      if (have_app) chk8("rnd_app_rdata", app_rdata1, m_app_exp);
      // next-state of the model
      m_app_exp = m_mem[aaddr];
      have_app = 1'b1;
      host_wr = 1'b0;
      haddr = m_ptr;
      rd_ok = rden && !if1.user_r_mem_empty && !upd && !wren;
      if (upd) begin
        m_ptr = maddr;
      end else if (wren) begin
        host_wr = 1'b1;
        m_ptr = m_ptr + 5'd1;
      end else if (rd_ok) begin
        m_ptr = m_ptr + 5'd1;
        pops++;
      end
      if (awren && !(host_wr && aaddr == haddr)) m_mem[aaddr] = awdata;
      if (host_wr) m_mem[haddr] = wdata;
      if (host_wr) m_dirty = 1'b1;
      else if (dclr) m_dirty = 1'b0;
      m_wren_last = wren;
      tick();
    end
    idle();
    $display("random run pops=%0d", pops);
    chk1("rnd_enough_pops", pops > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
